c5efa7_fpga_bup_qsys_button_ctrl: RTL and testbench

Avalon-MM slave controller for the board push-buttons. It synchronizes and debounces the raw button inputs and latches press events in an edge-capture register. Events are gated by an interrupt mask to drive a level IRQ. It sits between the board button pins and the Qsys interconnect, so software sees clean button state plus latched press events instead of raw pin levels.

---
 rtl/c5efa7_fpga_bup_qsys_button_ctrl.sv | 137 +++++++++++++
 tb/tb_c5efa7_fpga_bup_qsys_button_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/c5efa7_fpga_bup_qsys_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c5efa7_fpga_bup_qsys_button_ctrl
// Purpose  : Avalon-MM slave for the board push-buttons. It synchronizes and
//            debounces the raw active-low pins. It latches presses (1->0 of
//            the debounced state) in a W1C edge-capture register and drives
//            a level IRQ from the captured events gated by an interrupt mask.
// Ports    : clk        - system clock (single domain)
//            reset_n    - asynchronous active-low reset
//            address    - word address: 0 DATA, 1 IRQMASK, 2 EDGECAP, 3 RAW
//            chipselect - slave select
//            write_n    - active-low write strobe (qualified by chipselect)
//            writedata  - write data
//            in_port    - raw button pins, active-low, asynchronous to clk
//            readdata   - registered read data, zero-extended above WIDTH
//            irq        - level interrupt, OR of (EDGECAP & IRQMASK)
// Revision : 1.0 - initial release
// ============================================================================
module c5efa7_fpga_bup_qsys_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_upd;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd;
  logic             w_unused_wdata;

  // Bits of writedata above WIDTH are intentionally ignored.
  assign w_unused_wdata = ^writedata;

  // Two-flop synchronizer; resets to "released" so no false press at boot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff = r_sync2 ^ r_stable;

  // Per-bit debounce counter: counts consecutive disagreeing cycles; any
  // agreeing cycle restarts it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [c_CNT_W-1:0] r_cnt;

    assign w_upd[i] = w_diff[i] && (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (!w_diff[i] || w_upd[i]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '1;
    end else begin
      r_stable <= (r_stable & ~w_upd) | (r_sync2 & w_upd);
    end
  end

  // A press is an update of a bit that is currently released (1 -> 0).
  assign w_fall = w_upd & r_stable;

  assign w_wr  = chipselect && !write_n;
  assign w_clr = (w_wr && (address == 2'd2)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr && (address == 2'd1)) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Set has priority over a simultaneous software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_fall;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd[WIDTH-1:0] = r_stable;
      2'd1:    w_rd[WIDTH-1:0] = r_irqmask;
      2'd2:    w_rd[WIDTH-1:0] = r_edgecap;
      default: w_rd[WIDTH-1:0] = r_sync2;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= chipselect ? w_rd : 32'd0;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_c5efa7_fpga_bup_qsys_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c5efa7_fpga_bup_qsys_button_ctrl
// Purpose  : Scoreboard bench for the button controller (WIDTH=4,
//            DEBOUNCE_CYCLES=4). Read stimulus pushes the expected readdata
//            and irq; a monitor pops and compares one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c5efa7_fpga_bup_qsys_button_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        i;
  } exp_t;

  exp_t q[$];
  bit   rd_vld = 1'b0;

  c5efa7_fpga_bup_qsys_button_ctrl #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read-response marker: a read was sampled on the previous edge.
  always @(posedge clk) rd_vld <= chipselect && write_n;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h expected no response", readdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_data"}, readdata, e.d);
        chk({e.nm, "_irq"}, {31'd0, irq}, {31'd0, e.i});
      end
    end
  end

  // Every task below consumes whole clock edges and returns 1 ns after one.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    q.push_back('{nm, d, i});
    @(posedge clk);
    #1 chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1 chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic set_in(input logic [3:0] v);
    @(negedge clk);
    in_port = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // Post-reset register contents.
    rd(2'd0, 32'hF, 1'b0, "rst_data");
    rd(2'd1, 32'h0, 1'b0, "rst_mask");
    rd(2'd2, 32'h0, 1'b0, "rst_edgecap");
    rd(2'd3, 32'hF, 1'b0, "rst_raw");

    // Three-cycle glitch on bit 0 is rejected; RAW shows it.
    set_in(4'hE);
    idle(1);
    rd(2'd3, 32'hE, 1'b0, "glitch_raw");
    set_in(4'hF);
    idle(8);
    rd(2'd0, 32'hF, 1'b0, "glitch_data");
    rd(2'd2, 32'h0, 1'b0, "glitch_edgecap");

    // Read-only and out-of-range bits ignore writes.
    wr(2'd0, 32'h0);
    rd(2'd0, 32'hF, 1'b0, "ro_data");
    wr(2'd1, 32'hFFFF_FFF0);
    rd(2'd1, 32'h0, 1'b0, "mask_upper");

    // Press bit 0 with mask set: exact debounce latency.
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h1, 1'b0, "mask_rb");
    set_in(4'hE);
    idle(3);
    rd(2'd0, 32'hF, 1'b0, "press_k4");
    rd(2'd2, 32'h0, 1'b1, "press_k5");
    rd(2'd0, 32'hE, 1'b1, "press_data");
    rd(2'd2, 32'h1, 1'b1, "press_edgecap");
    set_in(4'hF);
    idle(8);
    rd(2'd0, 32'hF, 1'b1, "release_data");
    rd(2'd2, 32'h1, 1'b1, "release_edgecap");

    // Press bit 1, then partial W1C.
    set_in(4'hD);
    idle(8);
    set_in(4'hF);
    idle(8);
    wr(2'd1, 32'h3);
    rd(2'd2, 32'h3, 1'b1, "ec3");
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h2, 1'b1, "w1c_bit0");
    wr(2'd2, 32'h2);
    rd(2'd2, 32'h0, 1'b0, "w1c_bit1");

    // W1C on the same edge as the bit-2 press: set wins.
    set_in(4'hB);
    idle(4);
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h4, 1'b0, "set_wins");
    rd(2'd0, 32'hB, 1'b0, "bit2_data");
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h4, 1'b1, "mask4_irq");
    set_in(4'hF);
    idle(8);
    rd(2'd2, 32'h4, 1'b1, "bit2_release");
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h0, 1'b0, "bit2_clear");

    // Reset mid-debounce discards the count.
    set_in(4'hD);
    idle(3);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(5);
    rd(2'd0, 32'hF, 1'b0, "rstmid_r6");
    rd(2'd0, 32'hD, 1'b0, "rstmid_r7");
    rd(2'd2, 32'h2, 1'b0, "rstmid_edgecap");
    rd(2'd1, 32'h0, 1'b0, "rstmid_mask");

    idle(3);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
